// File: rtl/pll_pkg.sv
// Shared types for the ADPLL I/D counter path: pending-correction state and stats width.
// Also holds the pending-correction transition and drop rules used by id_counter.
package pll_pkg;

  typedef enum logic [1:0] {PEND_NONE, PEND_ADV, PEND_RET} pend_t;

  localparam int STATS_WIDTH = 16;

  // Opposite strobes cancel a pending correction; simultaneous strobes are ignored.
  function automatic pend_t pend_next(pend_t cur, logic carry, logic borrow);
    pend_t nxt;
    nxt = cur;
    if (carry && !borrow) begin
      nxt = (cur == PEND_RET) ? PEND_NONE : PEND_ADV;
    end else if (borrow && !carry) begin
      nxt = (cur == PEND_ADV) ? PEND_NONE : PEND_RET;
    end
    return nxt;
  endfunction

  function automatic logic pend_drop(pend_t cur, logic carry, logic borrow);
    return ((cur == PEND_ADV) && carry && !borrow) ||
           ((cur == PEND_RET) && borrow && !carry);
  endfunction

endpackage

// File: rtl/output_divider.sv
// Divide-by-DIV_N stage: toggles divOut_o once every DIV_N rising edges of the I/D output.
// rise_i marks the clock edge on which the I/D output goes high.
module output_divider #(
  parameter int DIV_N = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rise_i,
  output logic divOut_o
);

  localparam int DW = (DIV_N > 1) ? $clog2(DIV_N) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          div_out_q, div_out_d;
  logic          wrap;

  always_comb begin
    div_cnt_d = div_cnt_q;
    div_out_d = div_out_q;
    wrap      = (div_cnt_q == DW'(DIV_N - 1));
    if (rise_i) begin
      div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
      div_out_d = wrap ? ~div_out_q : div_out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      div_out_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_out_q <= div_out_d;
    end
  end

  assign divOut_o = div_out_q;

endmodule

// File: rtl/id_counter.sv
// I/D counter of the ADPLL: square wave whose half-periods stretch or shrink by one clock
// per carry/borrow correction, plus the feedback divider. ID_COUNTER_STATS_EN adds correction counters.
module id_counter
  import pll_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int DIV_N       = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic carry_i,
  input  logic borrow_i,
  output logic idOut_o,
  output logic idRise_o,
  output logic divOut_o,
  output logic dropped_o
`ifdef ID_COUNTER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] advCount_o,
  output logic [STATS_WIDTH-1:0] retCount_o
`endif
);

  localparam int HW = $clog2(HALF_PERIOD + 2);

  logic [HW-1:0] half_cnt_q, half_cnt_d;
  pend_t         pend_q, pend_d, pend_base;
  logic          id_q, id_d;
  logic          rise_q, rise_d;
  logic          drop_q, drop_d;
  logic          boundary;

  // A correction is consumed at the boundary, so strobes seen there start from NONE.
  always_comb begin
    boundary   = (half_cnt_q == HW'(1));
    pend_base  = boundary ? PEND_NONE : pend_q;
    pend_d     = pend_next(pend_base, carry_i, borrow_i);
    drop_d     = pend_drop(pend_base, carry_i, borrow_i);
    half_cnt_d = half_cnt_q - HW'(1);
    id_d       = id_q;
    rise_d     = 1'b0;
    if (boundary) begin
      id_d   = ~id_q;
      rise_d = ~id_q;
      unique case (pend_q)
        PEND_ADV: half_cnt_d = HW'(HALF_PERIOD - 1);
        PEND_RET: half_cnt_d = HW'(HALF_PERIOD + 1);
        default:  half_cnt_d = HW'(HALF_PERIOD);
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      half_cnt_q <= HW'(HALF_PERIOD);
      pend_q     <= PEND_NONE;
      id_q       <= 1'b0;
      rise_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      pend_q     <= pend_d;
      id_q       <= id_d;
      rise_q     <= rise_d;
      drop_q     <= drop_d;
    end
  end

  assign idOut_o   = id_q;
  assign idRise_o  = rise_q;
  assign dropped_o = drop_q;

  // Fed the unregistered rise so divOut_o changes on the same edge as idOut_o.
  output_divider #(
    .DIV_N(DIV_N)
  ) u_output_divider (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rise_i  (rise_d),
    .divOut_o(divOut_o)
  );

`ifdef ID_COUNTER_STATS_EN
  logic [STATS_WIDTH-1:0] adv_cnt_q, ret_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      adv_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else if (boundary) begin
      if ((pend_q == PEND_ADV) && (adv_cnt_q != '1)) adv_cnt_q <= adv_cnt_q + STATS_WIDTH'(1);
      if ((pend_q == PEND_RET) && (ret_cnt_q != '1)) ret_cnt_q <= ret_cnt_q + STATS_WIDTH'(1);
    end
  end

  assign advCount_o = adv_cnt_q;
  assign retCount_o = ret_cnt_q;
`endif

endmodule
